// File: rtl/mac_tx_arbiter_pkg.sv
// mac_tx_arbiter_pkg
// Shared definitions for the MAC transmit arbiter:
//   arb_state_t    - arbiter state encoding (IDLE=0, BUSY=1, ABORT=2, DRAIN=3)
//   FRAME_COUNT_W  - width of the completed-frame counter
//   ABORT_COUNT_W  - width of the saturating timeout-abort counter
package mac_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam int FRAME_COUNT_W = 16;
  localparam int ABORT_COUNT_W = 8;

endpackage

// File: rtl/mac_tx_arbiter_rr_pick.sv
// mac_tx_arbiter_rr_pick
// Combinational round-robin selector. Searches the request vector starting
// at last_grant+1 and wrapping modulo NUM_PORTS; the first requester found
// wins.
// Ports:
//   req        in  NUM_PORTS  request vector
//   last_grant in  GW         index granted most recently
//   valid      out 1          at least one request present
//   index      out GW         winning port index (0 when valid=0)
module mac_tx_arbiter_rr_pick
  import mac_tx_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int GW        = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        last_grant,
  output logic                 valid,
  output logic [GW-1:0]        index
);

  logic [GW-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest requester
  // (smallest offset after last_grant) is the final assignment.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = GW'((int'(last_grant) + k) % NUM_PORTS);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter
// Packet-level round-robin arbiter sharing the MAC transmit byte stream
// between NUM_PORTS requesters. Frames are never interleaved; a new frame
// is not started while the MAC TX FIFO reports almost-full.
// Optional feature macro: MAC_TX_ARB_TIMEOUT_EN builds the mid-frame source
// stall timeout, which emits one tuser=1/tlast=1 beat and then drains the
// rest of the stalled frame.
// Ports:
//   tx_clk, rst          clock, asynchronous active-high reset
//   s_tdata/tlast/tuser/tvalid/tready   per-port byte streams (port i at [8i+7:8i])
//   m_tdata/tlast/tuser/tvalid/tready   stream to the MAC
//   m_a_full             MAC FIFO almost full; blocks frame starts only
//   grant                current or last granted port
//   busy                 a frame is owned (BUSY, ABORT or DRAIN)
//   frame_count          completed frames forwarded (wraps)
//   abort_count          timeout aborts (saturates; 0 without the feature)
//   state_dbg            current arbiter state
//
// Handshake: a beat transfers on a rising tx_clk edge where valid and ready
// are both high. In BUSY the granted port is a zero-latency combinational
// pass-through, so s_tready[grant] mirrors m_tready and m_tvalid mirrors
// s_tvalid[grant]; ready never waits on valid.
module mac_tx_arbiter
  import mac_tx_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         tx_clk,
  input  logic                         rst,
  input  logic [NUM_PORTS*8-1:0]       s_tdata,
  input  logic [NUM_PORTS-1:0]         s_tlast,
  input  logic [NUM_PORTS-1:0]         s_tuser,
  input  logic [NUM_PORTS-1:0]         s_tvalid,
  output logic [NUM_PORTS-1:0]         s_tready,
  output logic [7:0]                   m_tdata,
  output logic                         m_tlast,
  output logic                         m_tuser,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  input  logic                         m_a_full,
  output logic [$clog2(NUM_PORTS)-1:0] grant,
  output logic                         busy,
  output logic [FRAME_COUNT_W-1:0]     frame_count,
  output logic [ABORT_COUNT_W-1:0]     abort_count,
  output logic [1:0]                   state_dbg
);

  localparam int GW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("mac_tx_arbiter: NUM_PORTS must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_t    state, state_nxt;
  logic [GW-1:0] last_grant;
  logic          pick_valid;
  logic [GW-1:0] pick_index;
  logic          start_frame;
  logic          frame_done;

  logic [7:0]    sel_data;
  logic          sel_last;
  logic          sel_user;
  logic          sel_valid;

  mac_tx_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .GW        (GW)
  ) u_rr_pick (
    .req        (s_tvalid),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_index)
  );

  // Granted-port view of the source streams.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == GW'(i)) begin
        sel_data  = s_tdata[i*8 +: 8];
        sel_last  = s_tlast[i];
        sel_user  = s_tuser[i];
        sel_valid = s_tvalid[i];
      end
    end
  end

  assign start_frame = (state == IDLE) && pick_valid && !m_a_full;
  // A tlast handshake completes the frame even if the timeout expires on
  // the same edge, because a handshake needs the source to be valid.
  assign frame_done  = (state == BUSY) && sel_valid && m_tready && sel_last;

`ifdef MAC_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;

  // Counts consecutive BUSY cycles with the granted source idle. A MAC
  // stall (valid high, ready low) clears it like any other valid cycle.
  assign timeout_hit = (state == BUSY) && !sel_valid &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != BUSY || sel_valid) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      abort_count <= '0;
    end else if (state == ABORT && m_tready && abort_count != '1) begin
      abort_count <= abort_count + 1'b1;
    end
  end
`else
  assign abort_count = '0;
`endif

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tlast   = 1'b0;
    m_tuser   = 1'b0;
    s_tready  = '0;
    case (state)
      IDLE: begin
        if (start_frame) state_nxt = BUSY;
      end
      BUSY: begin
        m_tvalid        = sel_valid;
        m_tdata         = sel_data;
        m_tlast         = sel_last;
        m_tuser         = sel_user;
        s_tready[grant] = m_tready;
        if (frame_done) begin
          state_nxt = IDLE;
        end
`ifdef MAC_TX_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_nxt = ABORT;
        end
`endif
      end
`ifdef MAC_TX_ARB_TIMEOUT_EN
      ABORT: begin
        // Synthetic last beat flagged as discard for the MAC.
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        if (m_tready) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Swallow the rest of the abandoned frame without forwarding it.
        s_tready[grant] = 1'b1;
        if (sel_valid && sel_last) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      last_grant  <= GW'(NUM_PORTS - 1);
      frame_count <= '0;
    end else begin
      if (start_frame) begin
        grant      <= pick_index;
        last_grant <= pick_index;
      end
      if (frame_done) frame_count <= frame_count + 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter
// Self-checking bench for mac_tx_arbiter with three ports. Sources are fed
// from per-port beat queues; the expected MAC stream is built from a
// frame-level round-robin model as frames are generated.
// Optional feature macro: MAC_TX_ARB_TIMEOUT_EN selects the abort scenario.
module tb_mac_tx_arbiter;
  import mac_tx_arbiter_pkg::*;

  localparam int NP = 3;
  localparam int GW = $clog2(NP);
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic tx_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 tx_clk = ~tx_clk;

  logic [NP*8-1:0]          s_tdata;
  logic [NP-1:0]            s_tlast, s_tuser, s_tvalid, s_tready;
  logic [7:0]               m_tdata;
  logic                     m_tlast, m_tuser, m_tvalid, m_tready, m_a_full;
  logic [GW-1:0]            grant;
  logic                     busy;
  logic [FRAME_COUNT_W-1:0] frame_count;
  logic [ABORT_COUNT_W-1:0] abort_count;
  logic [1:0]               state_dbg;

  mac_tx_arbiter #(
    .NUM_PORTS      (NP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_a_full    (m_a_full),
    .grant       (grant),
    .busy        (busy),
    .frame_count (frame_count),
    .abort_count (abort_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- bench state ----------------
  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    int         gap;
  } beat_t;

  beat_t       src_q[NP][$];
  int          gap_left[NP];
  logic [9:0]  exp_q[$];
  int          order_q[$];
  int          want[NP];
  int          model_last;
  logic [15:0] exp_frames;
  int          checks;
  int          errors;
  bit          rdy_rand, af_rand, af_val, tmo_phase;
  logic        smp_tvalid, smp_busy;
  logic [GW-1:0] smp_grant;

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_next(input int last, input bit [NP-1:0] req);
    for (int k = 1; k <= NP; k++) begin
      if (req[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  // Queue one frame on port p and its expected MAC beats. gap_idx/gap_len
  // force a source stall before one beat; abort replaces the tail of the
  // frame on the MAC side by a single discard beat.
  task automatic add_frame(input int p, input int len, input int max_gap,
                           input int gap_idx, input int gap_len, input bit abort);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = 8'($urandom_range(0, 255));
      b.l   = (i == len - 1);
      b.u   = ($urandom_range(0, 7) == 0);
      b.gap = (i == 0) ? 0 : (i == gap_idx) ? gap_len : int'($urandom_range(0, max_gap));
      src_q[p].push_back(b);
      if (!abort || i < gap_idx) exp_q.push_back({b.u, b.l, b.d});
    end
    if (abort) exp_q.push_back({1'b1, 1'b1, 8'h00});
    else       exp_frames++;
  endtask

  task automatic gen_phase(input int min_len, input int max_len, input int max_gap);
    bit [NP-1:0] req;
    int p;
    order_q.delete();
    for (int n = 0; n < 64; n++) begin
      req = '0;
      for (int i = 0; i < NP; i++) req[i] = (want[i] > 0);
      if (req == '0) break;
      p          = rr_next(model_last, req);
      model_last = p;
      want[p]--;
      order_q.push_back(p);
      add_frame(p, int'($urandom_range(min_len, max_len)), max_gap, -1, 0, 1'b0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_ports(input logic [NP-1:0] hs);
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      if (hs[p] && src_q[p].size() > 0) begin
        b = src_q[p].pop_front();
        if (src_q[p].size() > 0) gap_left[p] = src_q[p][0].gap;
      end
      if (gap_left[p] > 0) begin
        s_tvalid[p] = 1'b0;
        gap_left[p]--;
      end else if (src_q[p].size() > 0) begin
        s_tvalid[p]       = 1'b1;
        s_tdata[p*8 +: 8] = src_q[p][0].d;
        s_tlast[p]        = src_q[p][0].l;
        s_tuser[p]        = src_q[p][0].u;
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
        s_tuser[p]  = 1'b0;
      end
    end
  endtask

  // One cycle: sample and score at the falling edge, drive after the rise.
  task automatic tick();
    logic [NP-1:0] hs;
    logic [9:0]    e;
    @(negedge tx_clk);
    hs         = s_tvalid & s_tready;
    smp_tvalid = m_tvalid;
    smp_busy   = busy;
    smp_grant  = grant;
    if (!tmo_phase) check_eq("hs_balance", $countones(hs), {31'd0, m_tvalid && m_tready});
    if (m_tvalid && m_tready) begin
      check_eq("beat_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("out_beat", {m_tuser, m_tlast, m_tdata}, e);
      end
    end
    @(posedge tx_clk);
    #1;
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    m_a_full = af_rand ? ($urandom_range(0, 3) == 0) : af_val;
    drive_ports(hs);
  endtask

  function automatic int src_left();
    int n = 0;
    for (int p = 0; p < NP; p++) n += src_q[p].size();
    return n;
  endfunction

  task automatic run_until_empty(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || src_left() > 0) && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_exp_left"}, exp_q.size(), 0);
    check_eq({tag, "_src_left"}, src_left(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int exp_v[11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    checks = 0; errors = 0;
    exp_frames = '0;
    model_last = NP - 1;
    rdy_rand = 1'b0; af_rand = 1'b0; af_val = 1'b0; tmo_phase = 1'b0;
    for (int p = 0; p < NP; p++) gap_left[p] = 0;
    s_tdata  = 24'hA5C35A;
    s_tlast  = '1;
    s_tuser  = '1;
    s_tvalid = '0;
    m_tready = 1'b1;
    m_a_full = 1'b0;

    // Reset values.
    repeat (2) @(posedge tx_clk);
    @(negedge tx_clk);
    check_eq("rst_m_tvalid", m_tvalid, 0);
    check_eq("rst_m_tdata", m_tdata, 0);
    check_eq("rst_m_tlast", m_tlast, 0);
    check_eq("rst_m_tuser", m_tuser, 0);
    check_eq("rst_s_tready", s_tready, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_count", frame_count, 0);
    check_eq("rst_abort_count", abort_count, 0);
    check_eq("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(posedge tx_clk);
    #1;

    // Two 4-byte frames at once: p0, one idle cycle, p1.
    want = '{1, 1, 0};
    gen_phase(4, 4, 0);
    drive_ports('0);
    for (int i = 0; i < 11; i++) begin
      tick();
      check_eq($sformatf("t1_valid_%0d", i), smp_tvalid, exp_v[i]);
      if (i == 1) check_eq("t1_grant_a", smp_grant, order_q[0]);
      if (i == 6) check_eq("t1_grant_b", smp_grant, order_q[1]);
    end
    check_eq("t1_frame_count", frame_count, exp_frames);
    check_eq("t1_exp_left", exp_q.size(), 0);

    // Almost-full holds off arbitration; release grants one cycle later.
    af_val   = 1'b1;
    m_a_full = 1'b1;
    want = '{1, 1, 0};
    gen_phase(3, 3, 0);
    drive_ports('0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("af_hold_valid_%0d", i), smp_tvalid, 0);
      check_eq($sformatf("af_hold_busy_%0d", i), smp_busy, 0);
    end
    af_val   = 1'b0;
    m_a_full = 1'b0;
    tick();
    check_eq("af_release_idle", smp_tvalid, 0);
    tick();
    check_eq("af_release_valid", smp_tvalid, 1);
    check_eq("af_release_grant", smp_grant, order_q[0]);
    run_until_empty(200, "af");
    check_eq("af_frame_count", frame_count, exp_frames);

    // Randomized frames, gaps, MAC backpressure and almost-full.
    rdy_rand = 1'b1;
    af_rand  = 1'b1;
    for (int it = 0; it < 6; it++) begin
      for (int p = 0; p < NP; p++) want[p] = int'($urandom_range(0, 4));
      gen_phase(1, 6, 3);
      drive_ports('0);
      run_until_empty(3000, $sformatf("rnd%0d", it));
      repeat (2) tick();
      check_eq($sformatf("rnd%0d_frame_count", it), frame_count, exp_frames);
      check_eq($sformatf("rnd%0d_busy", it), smp_busy, 0);
    end
    check_eq("rnd_abort_count", abort_count, 0);

    // Port 1 sends 2 bytes, then its source stalls for TO cycles.
    rdy_rand = 1'b0;
    af_rand  = 1'b0;
    af_val   = 1'b0;
    m_tready = 1'b1;
    m_a_full = 1'b0;
    repeat (2) tick();
`ifdef MAC_TX_ARB_TIMEOUT_EN
    tmo_phase = 1'b1;
    add_frame(1, 5, 0, 2, TO, 1'b1);
    model_last = 1;
    drive_ports('0);
    run_until_empty(200, "tmo");
    repeat (2) tick();
    check_eq("tmo_abort_count", abort_count, 1);
    check_eq("tmo_frame_count", frame_count, exp_frames);
    check_eq("tmo_busy", smp_busy, 0);
`else
    add_frame(1, 5, 0, 2, 3 * TO, 1'b0);
    model_last = 1;
    drive_ports('0);
    run_until_empty(200, "stall");
    repeat (2) tick();
    check_eq("stall_abort_count", abort_count, 0);
    check_eq("stall_frame_count", frame_count, exp_frames);
    check_eq("stall_busy", smp_busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Packet-level round-robin arbiter that shares the MAC transmit byte stream between several requesters, e.g. the sample packetiser and the control/reply path. It sits in the `tx_clk` domain directly in front of the MAC transmit interface. It never interleaves bytes of different frames. It holds off new frames while the MAC TX FIFO is almost full. Optionally it aborts a frame whose source stalls mid-frame, using `tuser`, which the MAC treats as "discard frame".

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 1024: consecutive mid-frame cycles with the granted `s_tvalid` low before an abort. Used only with the timeout feature.

Ports (one clock `tx_clk`; reset `rst` is asynchronous and active-high):
- `tx_clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `s_tdata` in NUM_PORTS*8: requester bytes. Port i occupies bits [8i+7:8i].
- `s_tlast` in NUM_PORTS: last byte of frame, per port.
- `s_tuser` in NUM_PORTS: requester-side frame abort, passed through unchanged.
- `s_tvalid` in NUM_PORTS: per-port valid.
- `s_tready` out NUM_PORTS: per-port ready.
- `m_tdata` out 8: to MAC `tx_tdata`.
- `m_tlast` out 1: to MAC `tx_tlast`.
- `m_tuser` out 1: to MAC `tx_tuser`.
- `m_tvalid` out 1: to MAC `tx_tvalid`.
- `m_tready` in 1: from MAC `tx_tready`.
- `m_a_full` in 1: from MAC `tx_a_full`. Blocks the start of a new frame only.
- `grant` out $clog2(NUM_PORTS): index of the current or last granted port.
- `busy` out 1: high while a frame is owned (BUSY, ABORT or DRAIN).
- `frame_count` out 16: completed frames forwarded. Wraps.
- `abort_count` out 8: timeout aborts. Saturates at 255.

## Operation
- The state machine has four states: IDLE, BUSY, ABORT and DRAIN.
- **IDLE**
  - Outputs: `m_tvalid`=0 and all `s_tready`=0.
  - Arbitration happens when any `s_tvalid` is set and `m_a_full`=0.
  - The arbiter picks the first requesting port searching from `last_grant+1` with modulo-NUM_PORTS wrap.
  - On a pick, register `grant` and `last_grant` and go to BUSY.
- **BUSY**
  - Combinational pass-through of the granted port: `m_tdata/m_tlast/m_tuser/m_tvalid` = port[`grant`], and `s_tready[grant]` = `m_tready`.
  - All other `s_tready` are 0.
  - On a handshake with `m_tlast`=1, increment `frame_count` and go to IDLE.
  - A beat with `s_tuser`=1 is passed through as-is; it ends the frame only if `tlast` is also set.
  - `m_a_full` rising mid-frame does not interrupt the frame; backpressure comes only via `m_tready`.
- **ABORT** (timeout feature only)
  - Drive `m_tvalid`=1, `m_tlast`=1, `m_tuser`=1 and `m_tdata`=0, with all `s_tready`=0.
  - On `m_tready`, increment `abort_count` (saturating) and go to DRAIN.
- **DRAIN**
  - `s_tready[grant]`=1 and `m_tvalid`=0; the remaining source bytes are discarded.
  - A handshake with `s_tlast[grant]`=1 returns the machine to IDLE.
  - `frame_count` is not incremented.
- `last_grant` resets to NUM_PORTS-1, so port 0 wins first after reset.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `m_tuser`=0, `s_tready`=0, `grant`=0, `busy`=0, `frame_count`=0, `abort_count`=0. Reset mid-frame drops the frame with no tlast emitted; the MAC is reset on the same `rst`.
- Arbitration latency is 1 cycle: a request seen in IDLE at cycle n gives BUSY at n+1, and the first beat can transfer at n+1.
- Each frame is followed by exactly one IDLE cycle. Back-to-back frames therefore cost 1 bubble.
- The data path is 0-latency combinational; there is no skid buffer.
- Timeout counter:
  - Cleared on grant and on every cycle where `s_tvalid[grant]`=1.
  - Increments while in BUSY with `s_tvalid[grant]`=0.
  - When it equals TIMEOUT_CYCLES-1 at a clock edge, the next state is ABORT.
  - `m_tready`=0 with `s_tvalid`=1 is a MAC stall, not a source stall, and does not count.
- Simultaneous events:
  - Requests and `m_a_full` in the same IDLE cycle: no grant.
  - A tlast handshake and timeout expiry in the same cycle: the tlast wins and the frame completes.

## Configuration
- `MAC_TX_ARB_TIMEOUT_EN` defined: the timeout counter and the ABORT/DRAIN states are built, and `abort_count` is live.
- Undefined: no counter and no ABORT/DRAIN states; a stalled source holds the grant indefinitely, and `abort_count` is tied to 0.

## Structure
- The shared package holds:
  - the state encoding enum (IDLE=0, BUSY=1, ABORT=2, DRAIN=3);
  - the `FRAME_COUNT_W`=16 and `ABORT_COUNT_W`=8 constants.
- One sub-module, `rr_pick`: combinational round-robin selector with inputs request vector and `last_grant`, and outputs `valid` and `index`.

## Test plan
- Two ports each present a 4-byte frame simultaneously after reset, with `m_tready`=1. Port 0's frame goes out, then 1 idle cycle, then port 1's frame; `frame_count`=2.
- Port 0 streams frames continuously while port 1 requests once. Order is p0, p1, p0; port 1 waits at most one frame.
- `m_a_full`=1 while both ports request: `m_tvalid` stays 0. Release it: a grant follows 1 cycle later.
- `m_a_full` asserts mid-frame: the frame completes unchanged.
- `m_tready` toggles 1,0,1,0 during a 6-byte frame: every byte appears exactly once and in order, and `s_tready` follows `m_tready`.
- With `MAC_TX_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=8, port 1 sends 2 bytes then drops valid for 8 cycles:
  - one beat with `m_tlast`=1, `m_tuser`=1, `m_tdata`=0 is emitted;
  - `abort_count`=1;
  - port 1's remaining 3 bytes through tlast are drained with no `m_tvalid`;
  - `frame_count` is unchanged.
